nn_instr_sequencer: RTL and testbench
=====================================

Name: nn_instr_sequencer

Overview:
- Instruction fetch/sequence controller for the neural-network core.
- Owns the address and enable lines of the 128x8 instruction RAM, a combinational-read memory with tri-stated data when disabled.
- Walks the program from address 0 on `start` and dispatches EXEC arguments (layer sizes, neuron counts) to the datapath over a valid/ready handshake.
- Executes JMP, SETCNT and DJNZ locally; stops on HALT.

Parameters:
- PROG_DEPTH, 128, number of valid instruction words; PC must stay below this.
- ADDR_W, 8, instruction RAM address width.
- CNT_W, 6, loop counter width.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins execution at address 0 when idle.
- instr_addr  output  ADDR_W  instruction RAM address (PC).
- instr_en  output  1  instruction RAM enable.
- instr_data  input  8  instruction RAM read data.
- cmd_valid  output  1  datapath command valid.
- cmd_arg  output  6  datapath command argument.
- cmd_ready  input  1  datapath accepts command.
- busy  output  1  program running.
- done  output  1  program halted normally; level.
- error  output  1  program aborted on PC fault; level.

Behaviour:
- Encoding, instr[7:6] = opcode, instr[5:0] = arg:
  - 00 HALT.
  - 01 EXEC arg.
  - 10 JMP to {2'b0,arg}.
  - 11 SETCNT/DJNZ, selected by arg[5]:
    - arg[5]=0: SETCNT, cnt <= arg[4:0].
    - arg[5]=1: DJNZ to {3'b0,arg[4:0]}.
- Reset values: instr_addr=0, instr_en=0, cmd_valid=0, cmd_arg=0, busy=0, done=0, error=0, pc=0, cnt=0, ir=0, state IDLE.
- States: IDLE, FETCH, DECODE, DISPATCH, HALTED.
- IDLE: on start, pc<=0, clear done/error, busy<=1, go to FETCH.
  - start in any other state is ignored.
- FETCH: instr_en=1, instr_addr=pc; ir<=instr_data at cycle end; go to DECODE.
  - instr_en is 0 in every other state.
- DECODE, by opcode:
  - HALT: go to HALTED.
  - EXEC: cmd_arg<=arg, cmd_valid<=1, go to DISPATCH.
  - JMP: pc<=target, go to FETCH.
  - SETCNT: cnt<=arg[4:0], pc<=pc+1, go to FETCH.
  - DJNZ, cnt>1: cnt<=cnt-1, pc<=target.
  - DJNZ, cnt<=1: cnt<=0, pc<=pc+1 (fall through).
- Loop count rule: a body followed by DJNZ after SETCNT n runs max(n,1) times.
- DISPATCH:
  - cmd_valid and cmd_arg are held stable until cmd_ready.
  - On the cycle with cmd_valid&&cmd_ready: cmd_valid<=0, pc<=pc+1, go to FETCH.
- Latency: EXEC with cmd_ready tied high takes 3 cycles. Every other instruction takes 2 cycles.
- HALTED:
  - busy=0.
  - done=1, or error=1 for a fault.
  - Hold until the next start, which restarts from address 0.
- PC fault, checked in DECODE: pc+1 >= PROG_DEPTH on increment, or a jump/DJNZ target >= PROG_DEPTH.
  - Result: error<=1, done<=0, go to HALTED.
  - No dispatch occurs for the faulting instruction.
- EXEC on the last address: the dispatch completes first. The fault is flagged when the increment happens, in the DISPATCH handshake cycle.
- Reset mid-operation: everything returns to reset values immediately, including an outstanding cmd_valid.

Optional Feature:
- SEQ_PERF_CNT_EN defined:
  - Adds output retired_cnt [15:0].
  - Counts retired instructions; HALT and faulting instructions are not counted.
  - Cleared on start and on reset; saturates at 16'hFFFF.
- Undefined: port and counter are absent.

Decomposition:
- Package nn_seq_pkg holds:
  - opcode localparams OP_HALT, OP_EXEC, OP_JMP, OP_CNT;
  - state encodings;
  - field widths OPC_W=2, ARG_W=6.
- One natural sub-module: nn_seq_loop_ctr, holding cnt with load/decrement and the "taken" flag.
- The FSM and PC stay in the top module.

Test Plan:
- Program {8'h42,8'h42,8'h43,8'h00}, cmd_ready=1 -> cmd_arg sequence 2,2,3; done=1 after 11 cycles from start; busy low after.
- Program {8'hC3,8'h45,8'hE1,8'h00}, i.e. SETCNT 3, EXEC 5, DJNZ 1, HALT -> exactly 3 EXEC 5 handshakes, then done.
- EXEC with cmd_ready low for 5 cycles -> cmd_valid/cmd_arg stable for 5 cycles; pc advances only after ready; single acceptance.
- PROG_DEPTH=4, program {8'h41,8'h41,8'h41,8'h41} -> 4 dispatches; error=1 on the last handshake; done=0. Separately, JMP 8'h8A -> error, no dispatch.
- rst_n asserted while in DISPATCH -> cmd_valid=0, busy=0, instr_en=0 immediately. A later start reruns from address 0.
- start pulsed while busy -> ignored, program unaffected. With SEQ_PERF_CNT_EN, the first test yields retired_cnt=3.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared opcodes, field widths and FSM state encoding
// for the NN instruction sequencer.
package nn_seq_pkg;

   localparam int OPC_W = 2;
   localparam int ARG_W = 6;

   localparam logic [OPC_W-1:0] OP_HALT = 2'b00;
   localparam logic [OPC_W-1:0] OP_EXEC = 2'b01;
   localparam logic [OPC_W-1:0] OP_JMP  = 2'b10;
   localparam logic [OPC_W-1:0] OP_CNT  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_DISPATCH,
      S_HALTED
   } state_t;

endpackage

// File: rtl/nn_seq_loop_ctr.sv
// Loop counter for SETCNT/DJNZ; taken means the
// DJNZ branch goes back to its target.
module nn_seq_loop_ctr #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             taken
);

   logic [CNT_W-1:0] cnt;

   assign taken = (cnt > CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec)
         cnt <= taken ? cnt - 1'b1 : '0;
   end

endmodule

// File: rtl/nn_instr_sequencer.sv
// Instruction fetch/sequence FSM for the NN core.
// Define SEQ_PERF_CNT_EN to add the retired_cnt port.
module nn_instr_sequencer
   import nn_seq_pkg::*;
#(
   parameter int PROG_DEPTH = 128,
   parameter int ADDR_W     = 8,
   parameter int CNT_W      = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              instr_en,
   input  logic [7:0]        instr_data,
   output logic              cmd_valid,
   output logic [ARG_W-1:0]  cmd_arg,
   input  logic              cmd_ready,
   output logic              busy,
   output logic              done,
   output logic              error
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [15:0]       retired_cnt
`endif
);

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(PROG_DEPTH);

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic [7:0]        ir, ir_n;
   logic [ARG_W-1:0]  arg_n;
   logic              cv_n, busy_n, done_n, err_n;
   logic              fault, retire, clr;
   logic              cnt_load, cnt_dec, cnt_taken;

   logic [OPC_W-1:0]  opc;
   logic [ARG_W-1:0]  arg;
   logic [ADDR_W:0]   pc_inc, jmp_tgt, djnz_tgt;
   logic              inc_flt, jmp_flt, djnz_flt;
   logic              is_setcnt, is_djnz;

   assign opc       = ir[7:6];
   assign arg       = ir[5:0];
   assign pc_inc    = {1'b0, pc} + 1'b1;
   assign jmp_tgt   = (ADDR_W+1)'(arg);
   assign djnz_tgt  = (ADDR_W+1)'(arg[4:0]);
   assign inc_flt   = (pc_inc >= DEPTH);
   assign jmp_flt   = (jmp_tgt >= DEPTH);
   assign djnz_flt  = (djnz_tgt >= DEPTH);
   assign is_setcnt = (opc == OP_CNT) && !arg[5];
   assign is_djnz   = (opc == OP_CNT) && arg[5];

   assign instr_en   = (state == S_FETCH);
   assign instr_addr = pc;

   nn_seq_loop_ctr #(.CNT_W(CNT_W)) u_loop (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (CNT_W'(arg[4:0])),
      .taken    (cnt_taken)
   );

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      ir_n     = ir;
      arg_n    = cmd_arg;
      cv_n     = cmd_valid;
      busy_n   = busy;
      done_n   = done;
      err_n    = error;
      fault    = 1'b0;
      retire   = 1'b0;
      clr      = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state)
         S_IDLE, S_HALTED: begin
            if (start) begin
               pc_n    = '0;
               done_n  = 1'b0;
               err_n   = 1'b0;
               busy_n  = 1'b1;
               clr     = 1'b1;
               state_n = S_FETCH;
            end
         end
         S_FETCH: begin
            ir_n    = instr_data;
            state_n = S_DECODE;
         end
         S_DECODE: begin
            unique case (1'b1)
               opc == OP_HALT: begin
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = S_HALTED;
               end
               opc == OP_EXEC: begin
                  arg_n   = arg;
                  cv_n    = 1'b1;
                  state_n = S_DISPATCH;
               end
               opc == OP_JMP: begin
                  fault   = jmp_flt;
                  pc_n    = jmp_tgt[ADDR_W-1:0];
                  retire  = !jmp_flt;
                  state_n = S_FETCH;
               end
               is_setcnt: begin
                  fault    = inc_flt;
                  cnt_load = !inc_flt;
                  pc_n     = pc_inc[ADDR_W-1:0];
                  retire   = !inc_flt;
                  state_n  = S_FETCH;
               end
               is_djnz: begin
                  fault   = cnt_taken ? djnz_flt : inc_flt;
                  cnt_dec = !fault;
                  pc_n    = cnt_taken ? djnz_tgt[ADDR_W-1:0]
                                      : pc_inc[ADDR_W-1:0];
                  retire  = !fault;
                  state_n = S_FETCH;
               end
               default: ;
            endcase
         end
         S_DISPATCH: begin
            if (cmd_ready) begin
               cv_n    = 1'b0;
               fault   = inc_flt;
               pc_n    = pc_inc[ADDR_W-1:0];
               retire  = !inc_flt;
               state_n = S_FETCH;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // a fault overrides whatever the opcode chose
      if (fault) begin
         pc_n    = pc;
         busy_n  = 1'b0;
         done_n  = 1'b0;
         err_n   = 1'b1;
         state_n = S_HALTED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= '0;
         ir        <= '0;
         cmd_arg   <= '0;
         cmd_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         ir        <= ir_n;
         cmd_arg   <= arg_n;
         cmd_valid <= cv_n;
         busy      <= busy_n;
         done      <= done_n;
         error     <= err_n;
      end
   end

`ifdef SEQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired_cnt <= '0;
      else if (clr)
         retired_cnt <= '0;
      else if (retire && retired_cnt != 16'hFFFF)
         retired_cnt <= retired_cnt + 1'b1;
   end
`else
   logic unused_perf;
   assign unused_perf = clr ^ retire;
`endif

endmodule

// File: tb/tb_nn_instr_sequencer.sv
// Bench for nn_instr_sequencer: instance 0 uses PROG_DEPTH=128,
// instance 1 uses PROG_DEPTH=4; both run the same stimulus.
module tb_nn_instr_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] ad [2];
   logic       en [2];
   logic [7:0] dt [2];
   logic       cv [2];
   logic [5:0] ca [2];
   logic       rd [2];
   logic       by [2];
   logic       dn [2];
   logic       er [2];
`ifdef SEQ_PERF_CNT_EN
   logic [15:0] rc [2];
`endif

   logic [7:0] mem [2][256];

   int checks = 0;
   int fails  = 0;

   logic [5:0] got   [2][$];
   logic [5:0] exp_q [2][$];
   int         n_fin [2];
   int         m_cyc [2];
   int         m_ret [2];
   bit         m_done [2];
   bit         m_err  [2];
   bit         m_ok   [2];

   nn_instr_sequencer u0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .instr_addr (ad[0]),
      .instr_en   (en[0]),
      .instr_data (dt[0]),
      .cmd_valid  (cv[0]),
      .cmd_arg    (ca[0]),
      .cmd_ready  (rd[0]),
      .busy       (by[0]),
      .done       (dn[0]),
      .error      (er[0])
`ifdef SEQ_PERF_CNT_EN
      ,
      .retired_cnt(rc[0])
`endif
   );

   nn_instr_sequencer #(.PROG_DEPTH(4)) u1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .instr_addr (ad[1]),
      .instr_en   (en[1]),
      .instr_data (dt[1]),
      .cmd_valid  (cv[1]),
      .cmd_arg    (ca[1]),
      .cmd_ready  (rd[1]),
      .busy       (by[1]),
      .done       (dn[1]),
      .error      (er[1])
`ifdef SEQ_PERF_CNT_EN
      ,
      .retired_cnt(rc[1])
`endif
   );

   assign dt[0] = en[0] ? mem[0][ad[0]] : 8'h00;
   assign dt[1] = en[1] ? mem[1][ad[1]] : 8'h00;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int k,
                      input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s[%0d] got=%0d expected=%0d", nm, k, act, exp);
      end
   endtask

   // handshake capture and hold-stability check, sampled mid-cycle
   initial begin
      bit         hold [2];
      logic [5:0] harg [2];
      hold[0] = 1'b0;
      hold[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst_n && hold[k]) begin
               checks++;
               if (!(cv[k] && ca[k] == harg[k])) begin
                  fails++;
                  $display("FAIL stall_hold[%0d] valid=%0b arg=%0d expected valid=1 arg=%0d",
                           k, cv[k], ca[k], harg[k]);
               end
            end
            if (rst_n && cv[k] && rd[k])
               got[k].push_back(ca[k]);
            hold[k] = rst_n && cv[k] && !rd[k];
            harg[k] = ca[k];
         end
      end
   end

   // instruction-level interpreter; cnt starts at 0 (after reset)
   task automatic model(input int k);
      int         pc, cnt, dep;
      logic [7:0] ins;
      logic [5:0] a;
      dep = (k == 1) ? 4 : 128;
      pc  = 0;
      cnt = 0;
      exp_q[k].delete();
      m_cyc[k]  = 0;
      m_ret[k]  = 0;
      m_done[k] = 1'b0;
      m_err[k]  = 1'b0;
      m_ok[k]   = 1'b0;
      for (int s = 0; s < 64 && !m_ok[k]; s++) begin
         ins = mem[k][pc];
         a   = ins[5:0];
         m_cyc[k] += (ins[7:6] == 2'b01) ? 3 : 2;
         case (ins[7:6])
            2'b00: begin
               m_done[k] = 1'b1;
               m_ok[k]   = 1'b1;
            end
            2'b01: begin
               exp_q[k].push_back(a);
               if (pc + 1 >= dep) m_err[k] = 1'b1;
               else begin pc++; m_ret[k]++; end
            end
            2'b10: begin
               if (int'(a) >= dep) m_err[k] = 1'b1;
               else begin pc = int'(a); m_ret[k]++; end
            end
            default: begin
               if (!a[5]) begin
                  if (pc + 1 >= dep) m_err[k] = 1'b1;
                  else begin cnt = int'(a[4:0]); pc++; m_ret[k]++; end
               end else if (cnt > 1) begin
                  if (int'(a[4:0]) >= dep) m_err[k] = 1'b1;
                  else begin cnt--; pc = int'(a[4:0]); m_ret[k]++; end
               end else begin
                  if (pc + 1 >= dep) m_err[k] = 1'b1;
                  else begin cnt = 0; pc++; m_ret[k]++; end
               end
            end
         endcase
         if (m_err[k]) m_ok[k] = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run(input bit rnd, input bit poke);
      for (int k = 0; k < 2; k++) begin
         got[k].delete();
         n_fin[k] = -1;
      end
      pulse_start();
      for (int c = 1; c <= 3000; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++)
            if (n_fin[k] < 0 && (dn[k] || er[k])) n_fin[k] = c;
         start = poke && (c == 3 || c == 6);
         if (rnd)
            for (int k = 0; k < 2; k++) rd[k] = 1'($urandom_range(0, 1));
         if (n_fin[0] >= 0 && n_fin[1] >= 0) break;
      end
      start = 1'b0;
   endtask

   task automatic verify(input int k, input bit chk_cyc);
      chk("finished", k, int'(n_fin[k] >= 0), 1);
      chk("n_dispatch", k, got[k].size(), exp_q[k].size());
      for (int i = 0; i < exp_q[k].size() && i < got[k].size(); i++)
         chk("cmd_arg", k, int'(got[k][i]), int'(exp_q[k][i]));
      chk("done", k, int'(dn[k]), int'(m_done[k]));
      chk("error", k, int'(er[k]), int'(m_err[k]));
      chk("busy_after", k, int'(by[k]), 0);
      chk("en_after", k, int'(en[k]), 0);
      if (chk_cyc) chk("cycles", k, n_fin[k], m_cyc[k]);
`ifdef SEQ_PERF_CNT_EN
      chk("retired", k, int'(rc[k]), m_ret[k]);
`endif
   endtask

   task automatic load_prog(input logic [31:0] prog);
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 256; j++) mem[k][j] = 8'h00;
         for (int j = 0; j < 4; j++) mem[k][j] = prog[31-8*j -: 8];
      end
   endtask

   typedef struct packed {
      logic [31:0] prog;
      logic [15:0] args;
      logic [2:0]  nd;
      logic        er0;
      logic        er1;
      logic [7:0]  cyc0;
      logic [7:0]  cyc1;
   } vec_t;

   vec_t tv [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{32'h42424300, 16'h2230, 3'd3, 1'b0, 1'b0, 8'd11, 8'd11};
      tv[1] = '{32'hC345E100, 16'h5550, 3'd3, 1'b0, 1'b0, 8'd19, 8'd19};
      tv[2] = '{32'h41414141, 16'h1111, 3'd4, 1'b0, 1'b1, 8'd14, 8'd12};
      tv[3] = '{32'h8A000000, 16'h0000, 3'd0, 1'b0, 1'b1, 8'd4,  8'd2};
      tv[4] = '{32'h00000000, 16'h0000, 3'd0, 1'b0, 1'b0, 8'd2,  8'd2};
      tv[5] = '{32'h82410000, 16'h0000, 3'd0, 1'b0, 1'b0, 8'd4,  8'd4};
      tv[6] = '{32'hC047E100, 16'h7000, 3'd1, 1'b0, 1'b0, 8'd9,  8'd9};
      tv[7] = '{32'hC2E90000, 16'h0000, 3'd0, 1'b0, 1'b1, 8'd6,  8'd4};
      tv[8] = '{32'h414141C1, 16'h1110, 3'd3, 1'b0, 1'b1, 8'd13, 8'd11};

      rst_n = 1'b0;
      start = 1'b0;
      rd[0] = 1'b1;
      rd[1] = 1'b1;
      load_prog(32'h0);
      #17;
      for (int k = 0; k < 2; k++) begin
         chk("rst_addr", k, int'(ad[k]), 0);
         chk("rst_en", k, int'(en[k]), 0);
         chk("rst_valid", k, int'(cv[k]), 0);
         chk("rst_arg", k, int'(ca[k]), 0);
         chk("rst_busy", k, int'(by[k]), 0);
         chk("rst_done", k, int'(dn[k]), 0);
         chk("rst_error", k, int'(er[k]), 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         load_prog(tv[i].prog);
         rd[0] = 1'b1;
         rd[1] = 1'b1;
         run(1'b0, 1'b0);
         for (int k = 0; k < 2; k++) begin
            chk("tv_finished", k, int'(n_fin[k] >= 0), 1);
            chk("tv_n_dispatch", k, got[k].size(), int'(tv[i].nd));
            for (int j = 0; j < int'(tv[i].nd) && j < got[k].size(); j++)
               chk("tv_cmd_arg", k, int'(got[k][j]),
                   int'(tv[i].args[15-4*j -: 4]));
            chk("tv_error", k, int'(er[k]),
                int'(k == 1 ? tv[i].er1 : tv[i].er0));
            chk("tv_done", k, int'(dn[k]),
                int'(k == 1 ? !tv[i].er1 : !tv[i].er0));
            chk("tv_cycles", k, n_fin[k],
                int'(k == 1 ? tv[i].cyc1 : tv[i].cyc0));
            chk("tv_busy", k, int'(by[k]), 0);
`ifdef SEQ_PERF_CNT_EN
            if (i == 0) chk("tv_retired", k, int'(rc[k]), 3);
`endif
         end
      end

      // cmd_ready held low for 5 cycles while EXEC 5 waits
      load_prog(32'h45000000);
      rd[0] = 1'b0;
      rd[1] = 1'b0;
      got[0].delete();
      got[1].delete();
      pulse_start();
      repeat (2) begin @(posedge clk); #1; end
      for (int c = 0; c < 5; c++) begin
         for (int k = 0; k < 2; k++) begin
            chk("stall_valid", k, int'(cv[k]), 1);
            chk("stall_arg", k, int'(ca[k]), 5);
            chk("stall_pc", k, int'(ad[k]), 0);
         end
         @(posedge clk); #1;
      end
      rd[0] = 1'b1;
      rd[1] = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         chk("accept_valid", k, int'(cv[k]), 0);
         chk("accept_pc", k, int'(ad[k]), 1);
         chk("accept_en", k, int'(en[k]), 1);
      end
      for (int c = 0; c < 20 && !(dn[0] && dn[1]); c++) begin
         @(posedge clk); #1;
      end
      for (int k = 0; k < 2; k++) begin
         chk("stall_done", k, int'(dn[k]), 1);
         chk("stall_accepts", k, got[k].size(), 1);
      end

      // reset while a command is outstanding, then rerun
      rd[0] = 1'b0;
      rd[1] = 1'b0;
      pulse_start();
      repeat (3) begin @(posedge clk); #1; end
      for (int k = 0; k < 2; k++) chk("pre_rst_valid", k, int'(cv[k]), 1);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("midrst_valid", k, int'(cv[k]), 0);
         chk("midrst_busy", k, int'(by[k]), 0);
         chk("midrst_en", k, int'(en[k]), 0);
         chk("midrst_addr", k, int'(ad[k]), 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      rd[0] = 1'b1;
      rd[1] = 1'b1;
      run(1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         model(k);
         verify(k, 1'b1);
      end

      // start pulses while busy must not disturb the program
      load_prog(32'h42424300);
      run(1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         model(k);
         verify(k, 1'b1);
      end

      // random programs against the interpreter
      for (int it = 0; it < 30; it++) begin
         logic [7:0] b;
         bit         rnd;
         do_reset();
         for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 50; t++) begin
               for (int j = 0; j < 256; j++) mem[k][j] = 8'h00;
               for (int j = 0; j < (k == 1 ? 4 : 16); j++) begin
                  b = 8'($urandom_range(0, 255));
                  if (k == 0 && b[7:6] == 2'b10) b[5:4] = 2'b00;
                  if (k == 0 && b[7:5] == 3'b111) b[4] = 1'b0;
                  if (k == 1 && b[7:6] == 2'b10 && b[0]) b[5:2] = 4'h0;
                  if (k == 1 && b[7:5] == 3'b111 && b[1]) b[4:2] = 3'h0;
                  mem[k][j] = b;
               end
               model(k);
               if (m_ok[k]) break;
            end
            if (!m_ok[k]) begin
               mem[k][0] = 8'h00;
               model(k);
            end
         end
         rnd = it[0];
         for (int k = 0; k < 2; k++)
            rd[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         run(rnd, 1'b0);
         for (int k = 0; k < 2; k++) verify(k, !rnd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
